// File: rtl/ct_vfmau_hp_norm_pipe_if.sv
// Handshake and result bus for the binary16 normalization pipe.
// The master drives operands and consumes results; the slave is the pipe.
interface ct_vfmau_hp_norm_pipe_if;
    logic        in_vld;
    logic [15:0] in_data;
    logic        in_rdy;
    logic        out_vld;
    logic        out_rdy;
    logic        out_sign;
    logic [6:0]  out_exp;
    logic [9:0]  out_frac;
    logic        out_zero;
    logic        out_inf;
    logic        out_nan;
    logic        out_denorm;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_sign, out_exp, out_frac,
               out_zero, out_inf, out_nan, out_denorm
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_sign, out_exp, out_frac,
               out_zero, out_inf, out_nan, out_denorm
    );
endinterface

// File: rtl/ct_vfmau_hp_norm_pipe.sv
// Two-stage binary16 operand normalizer: classify, unbias exponent, normalize subnormals.
// Define CT_VFMAU_NORM_FTZ_EN to flush subnormal inputs to signed zero instead.
module ct_vfmau_hp_norm_pipe (
    input  logic                          forever_cpuclk,
    input  logic                          cpurst_b,
    input  logic                          pipe_flush,
    ct_vfmau_hp_norm_pipe_if.slave        norm_if
);

    logic        s1_vld;
    logic        s2_vld;
    logic        s1_adv;
    logic        s2_adv;
    logic [15:0] s1_data;

    logic        s1_sign;
    logic [4:0]  s1_exp_f;
    logic [9:0]  s1_frac_f;

    logic        nx_sign;
    logic [6:0]  nx_exp;
    logic [9:0]  nx_frac;
    logic        nx_zero;
    logic        nx_inf;
    logic        nx_nan;
    logic        nx_denorm;

    logic        s2_sign;
    logic [6:0]  s2_exp;
    logic [9:0]  s2_frac;
    logic        s2_zero;
    logic        s2_inf;
    logic        s2_nan;
    logic        s2_denorm;

    assign s2_adv         = !s2_vld || norm_if.out_rdy;
    assign s1_adv         = !s1_vld || s2_adv;
    assign norm_if.in_rdy = s1_adv;

    // Flush overrides any accept or advance on the same edge.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else if (pipe_flush) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            if (s1_adv)
                s1_vld <= norm_if.in_vld;
            if (s2_adv)
                s2_vld <= s1_vld;
        end
    end

`ifndef CT_VFMAU_NORM_FTZ_EN
    logic [3:0] ff1_cnt;
    logic [3:0] s1_cnt;
    logic [9:0] sub_frac;

    // Leading-one position: 1 for bit 9 down to 10 for bit 0, 0 when empty.
    always_comb begin
        ff1_cnt = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (norm_if.in_data[i])
                ff1_cnt = 4'(10 - i);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (norm_if.in_vld && s1_adv)
            s1_cnt <= ff1_cnt;
    end

    assign sub_frac = s1_frac_f << s1_cnt;
`endif

    always_ff @(posedge forever_cpuclk) begin
        if (norm_if.in_vld && s1_adv)
            s1_data <= norm_if.in_data;
    end

    assign s1_sign   = s1_data[15];
    assign s1_exp_f  = s1_data[14:10];
    assign s1_frac_f = s1_data[9:0];

    always_comb begin
        nx_sign   = s1_sign;
        nx_exp    = '0;
        nx_frac   = s1_frac_f;
        nx_zero   = 1'b0;
        nx_inf    = 1'b0;
        nx_nan    = 1'b0;
        nx_denorm = 1'b0;
        if (s1_exp_f == 5'h1f) begin
            if (s1_frac_f == '0)
                nx_inf = 1'b1;
            else
                nx_nan = 1'b1;
        end else if (s1_exp_f == '0) begin
            if (s1_frac_f == '0) begin
                nx_zero = 1'b1;
                nx_frac = '0;
            end else begin
`ifdef CT_VFMAU_NORM_FTZ_EN
                nx_zero   = 1'b1;
                nx_denorm = 1'b1;
                nx_frac   = '0;
`else
                // -14 - cnt, with -14 encoded as 7'h72
                nx_denorm = 1'b1;
                nx_exp    = 7'h72 - {3'b000, s1_cnt};
                nx_frac   = sub_frac;
`endif
            end
        end else begin
            nx_exp = {2'b00, s1_exp_f} - 7'd15;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (s2_adv && s1_vld) begin
            s2_sign   <= nx_sign;
            s2_exp    <= nx_exp;
            s2_frac   <= nx_frac;
            s2_zero   <= nx_zero;
            s2_inf    <= nx_inf;
            s2_nan    <= nx_nan;
            s2_denorm <= nx_denorm;
        end
    end

    assign norm_if.out_vld    = s2_vld;
    assign norm_if.out_sign   = s2_sign;
    assign norm_if.out_exp    = s2_exp;
    assign norm_if.out_frac   = s2_frac;
    assign norm_if.out_zero   = s2_zero;
    assign norm_if.out_inf    = s2_inf;
    assign norm_if.out_nan    = s2_nan;
    assign norm_if.out_denorm = s2_denorm;

endmodule

// File: tb/tb_ct_vfmau_hp_norm_pipe.sv
// Directed bench for ct_vfmau_hp_norm_pipe: vector table plus stall, flush and reset sequences.
module tb_ct_vfmau_hp_norm_pipe;

    logic clk;
    logic cpurst_b;
    logic pipe_flush;

    ct_vfmau_hp_norm_pipe_if norm_if ();

    ct_vfmau_hp_norm_pipe dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .pipe_flush     (pipe_flush),
        .norm_if        (norm_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] din;
        logic        sign;
        logic [6:0]  exp;
        logic [9:0]  frac;
        logic [3:0]  flags;   // {zero, inf, nan, denorm}
        logic        chk_exp;
    } vec_t;

    vec_t        vt [15];
    int          n_chk;
    int          n_fail;
    int          rx;
    logic [15:0] q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of streaming traffic; normal operands 0x3Cxx map to exp 0, frac = low bits.
    task automatic cyc(input logic vld, input logic [15:0] d, input logic ordy,
                       input logic fl, output logic acc);
        logic [15:0] e;
        @(negedge clk);
        norm_if.in_vld  = vld;
        norm_if.in_data = d;
        norm_if.out_rdy = ordy;
        pipe_flush      = fl;
        #1;
        if (norm_if.out_vld && norm_if.out_rdy && !fl) begin
            rx++;
            if (q.size() == 0) begin
                chk("spurious_out", 32'(norm_if.out_vld), 32'(0));
            end else begin
                e = q.pop_front();
                chk("stream_frac", 32'(norm_if.out_frac), 32'(e[9:0]));
                chk("stream_exp", 32'(norm_if.out_exp), 32'(0));
                chk("stream_flags", 32'({norm_if.out_zero, norm_if.out_inf,
                                         norm_if.out_nan, norm_if.out_denorm}), 32'(0));
            end
        end
        acc = vld && norm_if.in_rdy;
        if (fl)
            q.delete();
        else if (acc)
            q.push_back(d);
    endtask

    initial begin
        vec_t v;
        logic a;
        int   acc_n;
        int   guard;

        n_chk  = 0;
        n_fail = 0;
        rx     = 0;

        vt[0]  = '{16'h0001, 1'b0, 7'h68, 10'h000, 4'b0001, 1'b1};
        vt[1]  = '{16'h0300, 1'b0, 7'h71, 10'h200, 4'b0001, 1'b1};
        vt[2]  = '{16'h0200, 1'b0, 7'h71, 10'h000, 4'b0001, 1'b1};
        vt[3]  = '{16'h03FF, 1'b0, 7'h71, 10'h3FE, 4'b0001, 1'b1};
        vt[4]  = '{16'h0040, 1'b0, 7'h6E, 10'h000, 4'b0001, 1'b1};
        vt[5]  = '{16'h0055, 1'b0, 7'h6E, 10'h150, 4'b0001, 1'b1};
        vt[6]  = '{16'h8001, 1'b1, 7'h68, 10'h000, 4'b0001, 1'b1};
        vt[7]  = '{16'h3C00, 1'b0, 7'h00, 10'h000, 4'b0000, 1'b1};
        vt[8]  = '{16'h7BFF, 1'b0, 7'h0F, 10'h3FF, 4'b0000, 1'b1};
        vt[9]  = '{16'h0400, 1'b0, 7'h72, 10'h000, 4'b0000, 1'b1};
        vt[10] = '{16'hC000, 1'b1, 7'h01, 10'h000, 4'b0000, 1'b1};
        vt[11] = '{16'h8000, 1'b1, 7'h00, 10'h000, 4'b1000, 1'b1};
        vt[12] = '{16'h7C00, 1'b0, 7'h00, 10'h000, 4'b0100, 1'b0};
        vt[13] = '{16'h7E01, 1'b0, 7'h00, 10'h201, 4'b0010, 1'b0};
        vt[14] = '{16'hFC01, 1'b1, 7'h00, 10'h001, 4'b0010, 1'b0};

        cpurst_b        = 1'b0;
        pipe_flush      = 1'b0;
        norm_if.in_vld  = 1'b0;
        norm_if.in_data = '0;
        norm_if.out_rdy = 1'b1;
        #12;
        chk("reset_out_vld", 32'(norm_if.out_vld), 32'(0));
        chk("reset_in_rdy", 32'(norm_if.in_rdy), 32'(1));
        @(negedge clk);
        cpurst_b = 1'b1;
        #1;
        chk("post_reset_in_rdy", 32'(norm_if.in_rdy), 32'(1));

        // Single operands through the table, checking exact two-cycle latency.
        for (int i = 0; i < 15; i++) begin
            v = vt[i];
`ifdef CT_VFMAU_NORM_FTZ_EN
            if (v.flags == 4'b0001) begin
                v.exp   = '0;
                v.frac  = '0;
                v.flags = 4'b1001;
            end
`endif
            @(negedge clk);
            norm_if.in_vld  = 1'b1;
            norm_if.in_data = v.din;
            norm_if.out_rdy = 1'b1;
            #1;
            chk("vec_in_rdy", 32'(norm_if.in_rdy), 32'(1));
            @(negedge clk);
            norm_if.in_vld = 1'b0;
            #1;
            chk("vec_latency_early", 32'(norm_if.out_vld), 32'(0));
            @(negedge clk);
            #1;
            chk("vec_out_vld", 32'(norm_if.out_vld), 32'(1));
            chk("vec_sign", 32'(norm_if.out_sign), 32'(v.sign));
            if (v.chk_exp)
                chk("vec_exp", 32'(norm_if.out_exp), 32'(v.exp));
            chk("vec_frac", 32'(norm_if.out_frac), 32'(v.frac));
            chk("vec_flags", 32'({norm_if.out_zero, norm_if.out_inf,
                                  norm_if.out_nan, norm_if.out_denorm}), 32'(v.flags));
        end

        // Backpressure: four offers with out_rdy low fill exactly two stages.
        cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
        q.delete();
        rx    = 0;
        acc_n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'h3C01 + 16'(acc_n), 1'b0, 1'b0, a);
            if (a)
                acc_n++;
            if (i >= 2) begin
                chk("stall_out_vld", 32'(norm_if.out_vld), 32'(1));
                chk("stall_payload", 32'(norm_if.out_frac), 32'(10'h001));
            end
        end
        chk("stall_accepts", 32'(acc_n), 32'(2));
        chk("stall_in_rdy", 32'(norm_if.in_rdy), 32'(0));
        cyc(1'b1, 16'h3C03, 1'b1, 1'b0, a);
        chk("refill_in_rdy", 32'(a), 32'(1));
        guard = 0;
        while (rx < 3 && guard < 10) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
            guard++;
        end
        chk("drain_count", 32'(rx), 32'(3));
        chk("drain_queue_empty", 32'(q.size()), 32'(0));

        // Flush during a back-to-back stream.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 16'h3C10 + 16'(i), 1'b1, 1'b0, a);
            chk("stream_accept", 32'(a), 32'(1));
        end
        cyc(1'b1, 16'h3C20, 1'b1, 1'b1, a);
        cyc(1'b1, 16'h3C30, 1'b1, 1'b0, a);
        pipe_flush = 1'b0;
        chk("flush_out_vld", 32'(norm_if.out_vld), 32'(0));
        chk("post_flush_accept", 32'(a), 32'(1));
        cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
        chk("post_flush_early", 32'(norm_if.out_vld), 32'(0));
        rx = 0;
        cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
        chk("post_flush_out_vld", 32'(norm_if.out_vld), 32'(1));
        chk("post_flush_frac", 32'(norm_if.out_frac), 32'(10'h030));
        chk("post_flush_rx", 32'(rx), 32'(1));

        // Asynchronous reset with both stages full.
        cyc(1'b1, 16'h3C40, 1'b0, 1'b0, a);
        cyc(1'b1, 16'h3C41, 1'b0, 1'b0, a);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
        chk("full_out_vld", 32'(norm_if.out_vld), 32'(1));
        chk("full_in_rdy", 32'(norm_if.in_rdy), 32'(0));
        #1;
        cpurst_b = 1'b0;
        #1;
        chk("async_rst_out_vld", 32'(norm_if.out_vld), 32'(0));
        chk("async_rst_in_rdy", 32'(norm_if.in_rdy), 32'(1));
        q.delete();
        @(negedge clk);
        cpurst_b = 1'b1;
        rx = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
            chk("rst_release_out_vld", 32'(norm_if.out_vld), 32'(0));
            chk("rst_release_in_rdy", 32'(norm_if.in_rdy), 32'(1));
        end
        cyc(1'b1, 16'h3C55, 1'b1, 1'b0, a);
        guard = 0;
        while (rx < 1 && guard < 8) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, a);
            guard++;
        end
        chk("rst_recover_rx", 32'(rx), 32'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
